// File: rtl/alu_bitserial_if.sv
// ============================================================================
//  Module   : alu_bitserial_if
//  Purpose  : Request/response handshake bundle for the bit-serial ALU.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_bitserial_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ainv;
    logic             binv;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, ainv, binv, op, out_ready,
        input  in_ready, out_valid, result, zero, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, ainv, binv, op, out_ready,
        output in_ready, out_valid, result, zero, cout, overflow
    );
endinterface

`default_nettype wire

// File: rtl/alu_bitserial.sv
// ============================================================================
//  Module   : alu_bitserial
//  Purpose  : Bit-serial AND/OR/ADD/SLT ALU, one bit per cycle, LSB first.
//             Define ALU_SLT_SIGNED_FIX_EN for an overflow-correct signed SLT.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_bitserial #(
    parameter int WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_bitserial_if.slave   bus
);

    localparam int              c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 ainv_q, ainv_d;
    logic                 binv_q, binv_d;
    logic [1:0]           op_q, op_d;
    logic                 carry_q, carry_d;
    logic                 set_q, set_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 cout_q, cout_d;
    logic                 overflow_q, overflow_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    // Single shared 1-bit slice, indexed by the bit counter
    logic w_ar;
    logic w_br;
    logic w_sum;
    logic w_co;
    logic w_bit;
    logic w_less;

    assign w_ar  = a_q[cnt_q] ^ ainv_q;
    assign w_br  = b_q[cnt_q] ^ binv_q;
    assign w_sum = w_ar ^ w_br ^ carry_q;
    assign w_co  = (w_ar & w_br) | (w_ar & carry_q) | (w_br & carry_q);

    always_comb begin
        w_bit = 1'b0;
        case (op_q)
            2'b00:   w_bit = w_ar & w_br;
            2'b01:   w_bit = w_ar | w_br;
            2'b10:   w_bit = w_sum;
            default: w_bit = 1'b0;
        endcase
    end

`ifdef ALU_SLT_SIGNED_FIX_EN
    assign w_less = set_q ^ overflow_q;
`else
    assign w_less = set_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        ainv_d      = ainv_q;
        binv_d      = binv_q;
        op_d        = op_q;
        carry_d     = carry_q;
        set_d       = set_q;
        result_d    = result_q;
        zero_d      = zero_q;
        cout_d      = cout_q;
        overflow_d  = overflow_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d        = bus.a;
                    b_d        = bus.b;
                    ainv_d     = bus.ainv;
                    binv_d     = bus.binv;
                    op_d       = bus.op;
                    cnt_d      = '0;
                    carry_d    = bus.binv;
                    result_d   = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[cnt_q] = w_bit;
                carry_d         = w_co;
                if (cnt_q == c_LAST) begin
                    cout_d     = w_co;
                    overflow_d = carry_q ^ w_co;
                    set_d      = w_sum;
                    state_d    = ST_FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIN: begin
                // SLT wrote zeros during RUN; only bit 0 carries the answer
                if (op_q == 2'b11) begin
                    result_d[0] = w_less;
                end
                zero_d      = (result_d == '0);
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ainv_q      <= 1'b0;
            binv_q      <= 1'b0;
            op_q        <= 2'b00;
            carry_q     <= 1'b0;
            set_q       <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ainv_q      <= ainv_d;
            binv_q      <= binv_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            set_q       <= set_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            cout_q      <= cout_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_bitserial.sv
// ============================================================================
//  Module   : tb_alu_bitserial
//  Purpose  : Directed self-checking bench for alu_bitserial (WIDTH=32).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_bitserial;

    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;

    alu_bitserial_if #(.WIDTH(WIDTH)) bus ();

    alu_bitserial #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Issues one request from IDLE, scrambles the operand pins after accept,
    // and returns with out_valid high (or timed_out set) and out_ready low.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tai, input logic tbi, input logic [1:0] top,
                          output int lat, output bit timed_out);
        bus.a        = ta;
        bus.b        = tb_v;
        bus.ainv     = tai;
        bus.binv     = tbi;
        bus.op       = top;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = ~ta;
        bus.b        = ~tb_v;
        bus.ainv     = ~tai;
        bus.binv     = ~tbi;
        bus.op       = ~top;
        lat       = 0;
        timed_out = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.out_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic release_op();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        checks++; if ({bus.zero, bus.cout, bus.overflow} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.zero, bus.cout, bus.overflow}); end
    endtask

    task automatic test_add();
        int lat; bit to;
        run_op(32'd5, 32'd7, 1'b0, 1'b0, 2'b10, lat, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL add_timeout got=%b exp=0", to); end
        checks++; if (lat !== 33) begin failures++; $display("FAIL add_latency got=%0d exp=33", lat); end
        checks++; if (bus.result !== 32'd12) begin failures++; $display("FAIL add_result got=%h exp=0000000c", bus.result); end
        checks++; if ({bus.zero, bus.cout, bus.overflow} !== 3'b000) begin failures++; $display("FAIL add_flags got=%b exp=000", {bus.zero, bus.cout, bus.overflow}); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL add_in_ready got=%b exp=0", bus.in_ready); end
        release_op();
    endtask

    task automatic test_sub();
        int lat; bit to;
        run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 2'b10, lat, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL sub_timeout got=%b exp=0", to); end
        checks++; if (bus.result !== 32'h7FFF_FFFF) begin failures++; $display("FAIL sub_result got=%h exp=7fffffff", bus.result); end
        checks++; if ({bus.zero, bus.cout, bus.overflow} !== 3'b011) begin failures++; $display("FAIL sub_flags got=%b exp=011", {bus.zero, bus.cout, bus.overflow}); end
        release_op();
        run_op(32'h1234, 32'h1234, 1'b0, 1'b1, 2'b10, lat, to);
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL sub_eq_result got=%h exp=0", bus.result); end
        checks++; if ({bus.zero, bus.cout, bus.overflow} !== 3'b110) begin failures++; $display("FAIL sub_eq_flags got=%b exp=110", {bus.zero, bus.cout, bus.overflow}); end
        release_op();
    endtask

    task automatic test_slt();
        int lat; bit to;
        logic [31:0] exp_ovf_case;
`ifdef ALU_SLT_SIGNED_FIX_EN
        exp_ovf_case = 32'h1;
`else
        exp_ovf_case = 32'h0;
`endif
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 2'b11, lat, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL slt_timeout got=%b exp=0", to); end
        checks++; if (bus.result !== 32'h1) begin failures++; $display("FAIL slt_neg_result got=%h exp=00000001", bus.result); end
        checks++; if ({bus.zero, bus.cout, bus.overflow} !== 3'b010) begin failures++; $display("FAIL slt_neg_flags got=%b exp=010", {bus.zero, bus.cout, bus.overflow}); end
        release_op();
        run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 2'b11, lat, to);
        checks++; if (bus.result !== exp_ovf_case) begin failures++; $display("FAIL slt_ovf_result got=%h exp=%h", bus.result, exp_ovf_case); end
        checks++; if (bus.zero !== ~exp_ovf_case[0]) begin failures++; $display("FAIL slt_ovf_zero got=%b exp=%b", bus.zero, ~exp_ovf_case[0]); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL slt_ovf_overflow got=%b exp=1", bus.overflow); end
        release_op();
    endtask

    task automatic test_logic();
        int lat; bit to;
        run_op(32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 1'b0, 2'b00, lat, to);
        checks++; if (bus.result !== 32'h0000_00F0) begin failures++; $display("FAIL and_result got=%h exp=000000f0", bus.result); end
        checks++; if (bus.zero !== 1'b0) begin failures++; $display("FAIL and_zero got=%b exp=0", bus.zero); end
        release_op();
        run_op(32'h0000_F000, 32'h0000_000F, 1'b0, 1'b0, 2'b01, lat, to);
        checks++; if (bus.result !== 32'h0000_F00F) begin failures++; $display("FAIL or_result got=%h exp=0000f00f", bus.result); end
        release_op();
        run_op(32'h0, 32'h0, 1'b1, 1'b1, 2'b00, lat, to);
        checks++; if (bus.result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL nor_result got=%h exp=ffffffff", bus.result); end
        checks++; if ({bus.zero, bus.cout, bus.overflow} !== 3'b010) begin failures++; $display("FAIL nor_flags got=%b exp=010", {bus.zero, bus.cout, bus.overflow}); end
        release_op();
    endtask

    task automatic test_backpressure();
        int lat; bit to;
        run_op(32'd100, 32'd27, 1'b0, 1'b0, 2'b10, lat, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL bp_timeout got=%b exp=0", to); end
        bus.a = 32'd1; bus.b = 32'd1; bus.op = 2'b10; bus.ainv = 1'b0; bus.binv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hs[%0d] got=%b%b exp=10", i, bus.out_valid, bus.in_ready); end
            checks++; if (bus.result !== 32'd127 || {bus.zero, bus.cout, bus.overflow} !== 3'b000) begin failures++; $display("FAIL bp_hold[%0d] got=%h/%b exp=0000007f/000", i, bus.result, {bus.zero, bus.cout, bus.overflow}); end
        end
        bus.in_valid = 1'b0;
        release_op();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b%b exp=10", bus.in_ready, bus.out_valid); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_ghost got=%b%b exp=10", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_reset_midrun();
        bit seen;
        bus.a = 32'hDEAD_BEEF; bus.b = 32'h1; bus.ainv = 1'b0; bus.binv = 1'b0; bus.op = 2'b10;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rr_accept got=%b exp=0", bus.in_ready); end
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rr_idle got=%b%b exp=10", bus.in_ready, bus.out_valid); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL rr_result got=%h exp=0", bus.result); end
        seen = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rr_no_response got=%b exp=0", seen); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  first_c, second_c;
        bit  prev;
        first_c  = -1;
        second_c = -1;
        prev     = 1'b0;
        bus.a = 32'd3; bus.b = 32'd4; bus.ainv = 1'b0; bus.binv = 1'b0; bus.op = 2'b10;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid && !prev) begin
                checks++; if (bus.result !== 32'd7) begin failures++; $display("FAIL b2b_result got=%h exp=00000007", bus.result); end
                if (first_c < 0) first_c = cyc;
                else second_c = cyc;
            end
            prev = bus.out_valid;
            if (second_c >= 0) break;
        end
        bus.in_valid = 1'b0;
        checks++; if (first_c < 0 || second_c < 0) begin failures++; $display("FAIL b2b_timeout got=%0d,%0d exp=both seen", first_c, second_c); end
        checks++; if (second_c - first_c !== WIDTH + 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", second_c - first_c, WIDTH + 3); end
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b%b exp=10", bus.in_ready, bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ainv      = 1'b0;
        bus.binv      = 1'b0;
        bus.op        = 2'b00;
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
